// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of one single-port synchronous RAM.
// Commands are registered onto the RAM port; reads return two edges later.
module ram_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  ram_we_q, ram_we_d;
  logic                  a_valid_q, a_valid_d;
  logic                  a_owner_q, a_owner_d;
  logic                  b_valid_q, b_valid_d;
  logic                  b_owner_q, b_owner_d;

  logic                  gnt0_c, gnt1_c;
  logic                  xfer, sel1, we_sel;

  // last_grant_q holds the index of the port granted most recently
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (FIXED_PRIORITY || last_grant_q)
          gnt0_c = 1'b1;
        else
          gnt1_c = 1'b1;
      end else begin
        gnt0_c = req0;
        gnt1_c = req1;
      end
    end
  end

  assign gnt0   = gnt0_c;
  assign gnt1   = gnt1_c;
  assign sel1   = req1 & gnt1_c;
  assign xfer   = (req0 & gnt0_c) | sel1;
  assign we_sel = sel1 ? we1 : we0;

  always_comb begin
    last_grant_d = last_grant_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_we_d     = 1'b0;
    a_valid_d    = 1'b0;
    a_owner_d    = a_owner_q;
    b_valid_d    = a_valid_q;
    b_owner_d    = a_owner_q;
    if (xfer) begin
      last_grant_d = sel1;
      ram_addr_d   = sel1 ? addr1 : addr0;
      ram_din_d    = sel1 ? wdata1 : wdata0;
      ram_we_d     = we_sel;
      a_valid_d    = ~we_sel;
      a_owner_d    = sel1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      a_valid_q    <= 1'b0;
      a_owner_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      b_owner_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
      a_valid_q    <= a_valid_d;
      a_owner_q    <= a_owner_d;
      b_valid_q    <= b_valid_d;
      b_owner_q    <= b_owner_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_din_q;
  assign ram_we      = ram_we_q;

  // RAM output is registered, so stage B lines up with valid read data
  assign rvalid0 = b_valid_q & ~b_owner_q;
  assign rvalid1 = b_valid_q & b_owner_q;
  assign rdata0  = ram_data_out;
  assign rdata1  = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table with a read scoreboard,
// plus reset-in-flight and fixed-priority sequences.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [11:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata0, rdata1;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data_in;
  logic        ram_we;
  logic [7:0]  ram_dout;

  logic        fp_req0, fp_req1;
  logic        fp_we = 1'b0;
  logic [11:0] fp_addr = '0;
  logic [7:0]  fp_wd = '0;
  logic [7:0]  fp_rdout = '0;
  logic        fp_gnt0, fp_gnt1, fp_rv0, fp_rv1;
  logic [7:0]  fp_rd0, fp_rd1, fp_rdi;
  logic [11:0] fp_ra;
  logic        fp_rwe;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we),
    .ram_data_out(ram_dout)
  );

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(fp_req0), .req1(fp_req1), .we0(fp_we), .we1(fp_we),
    .addr0(fp_addr), .addr1(fp_addr), .wdata0(fp_wd), .wdata1(fp_wd),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rv0), .rvalid1(fp_rv1),
    .rdata0(fp_rd0), .rdata1(fp_rd1),
    .ram_addr(fp_ra), .ram_data_in(fp_rdi), .ram_we(fp_rwe),
    .ram_data_out(fp_rdout)
  );

  always #5 clk = ~clk;

  // single-port RAM: registered read, old data on write
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (reset) begin
      mem[1] <= 8'h11;
      mem[2] <= 8'h22;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data_in;
    end
    ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit r0, r1, w0, w1;
    logic [11:0] a0, a1;
    logic [7:0] d0, d1;
    bit g0, g1;
  } vec_t;

  typedef struct {
    bit port;
    logic [7:0] data;
    int due;
  } sb_t;

  vec_t       vt[$];
  sb_t        sbq[$];
  logic [7:0] exp_mem [0:4095];
  int         checks = 0;
  int         failures = 0;

  bit          pv, pw;
  logic [11:0] pa;
  logic [7:0]  pd;

  function automatic vec_t mk(bit r0, bit r1, bit w0, bit w1,
                              logic [11:0] a0, logic [11:0] a1,
                              logic [7:0] d0, logic [7:0] d1,
                              bit g0, bit g1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic zero_in();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  // compare read returns against the scoreboard at mid-cycle
  task automatic mon();
    sb_t e;
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      chk("missed_rvalid", 32'(e.due), 32'(cyc));
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      if (e.port == 1'b0) begin
        chk("rvalid0", 32'(rvalid0), 1);
        chk("rdata0", 32'(rdata0), 32'(e.data));
        chk("rvalid1_quiet", 32'(rvalid1), 0);
      end else begin
        chk("rvalid1", 32'(rvalid1), 1);
        chk("rdata1", 32'(rdata1), 32'(e.data));
        chk("rvalid0_quiet", 32'(rvalid0), 0);
      end
    end else if (rvalid0 || rvalid1) begin
      chk("spurious_rvalid", 32'({rvalid0, rvalid1}), 0);
    end
  endtask

  task automatic step(vec_t v);
    sb_t e;
    @(posedge clk);
    #1;
    if (pv) begin
      chk("ram_we", 32'(ram_we), 32'(pw));
      chk("ram_addr", 32'(ram_addr), 32'(pa));
      if (pw) chk("ram_data_in", 32'(ram_data_in), 32'(pd));
    end else begin
      chk("ram_we_idle", 32'(ram_we), 0);
    end
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    #3;
    mon();
    chk("gnt0", 32'(gnt0), 32'(v.g0));
    chk("gnt1", 32'(gnt1), 32'(v.g1));
    pv = 0;
    if ((v.r0 && v.g0) || (v.r1 && v.g1)) begin
      pv = 1;
      e.port = v.r1 && v.g1;
      pw = e.port ? v.w1 : v.w0;
      pa = e.port ? v.a1 : v.a0;
      pd = e.port ? v.d1 : v.d0;
      if (pw) begin
        exp_mem[pa] = pd;
      end else begin
        e.data = exp_mem[pa];
        e.due = cyc + 2;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    zero_in();
    #3;
    mon();
  endtask

  initial begin
    reset = 1;
    zero_in();
    fp_req0 = 0; fp_req1 = 0;
    pv = 0; pw = 0; pa = '0; pd = '0;
    exp_mem[1] = 8'h11;
    exp_mem[2] = 8'h22;

    for (int i = 0; i < 6; i++)
      vt.push_back(mk(1, 1, 0, 0, 12'h001, 12'h002, 0, 0,
                      (i % 2) == 0, (i % 2) == 1));
    vt.push_back(mk(1, 0, 1, 0, 12'h010, 0, 8'hA5, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 0, 12'h010, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 1, 0, 12'h7FF, 0, 8'h3C, 0, 1));
    vt.push_back(mk(1, 0, 0, 0, 12'h7FF, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(0, 1, 0, 1, 0, 12'(i), 0, 8'(8'h40 + i), 0, 1));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(0, 1, 0, 0, 0, 12'(i), 0, 0, 0, 1));
    vt.push_back(mk(1, 1, 1, 0, 12'h020, 12'h020, 8'h55, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 12'h020, 0, 0, 0, 1));

    // reset state, with both requests high
    repeat (2) @(posedge clk);
    #1;
    req0 = 1; req1 = 1; fp_req0 = 1; fp_req1 = 1;
    #3;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_fp_gnt", 32'({fp_gnt0, fp_gnt1}), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_din", 32'(ram_data_in), 0);
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 0);
    @(posedge clk);
    #1;
    zero_in();
    fp_req0 = 0; fp_req1 = 0;
    reset = 0;

    foreach (vt[i]) step(vt[i]);

    for (int k = 0; k < 10 && sbq.size() > 0; k++) idle_cycle();
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 0);

    // read accepted, then reset before its return
    @(posedge clk);
    #1;
    req0 = 1; addr0 = 12'h010;
    #3;
    mon();
    chk("pre_rst_gnt0", 32'(gnt0), 1);
    @(posedge clk);
    #1;
    reset = 1;
    sbq.delete();
    #3;
    chk("mid_rst_ram_we", 32'(ram_we), 0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 0);
    chk("mid_rst_gnt0", 32'(gnt0), 0);
    chk("mid_rst_rvalid0", 32'(rvalid0), 0);
    @(posedge clk);
    #1;
    zero_in();
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      idle_cycle();
      chk("post_rst_rvalid0", 32'(rvalid0), 0);
    end
    @(posedge clk);
    #1;
    req0 = 1; req1 = 1;
    #3;
    chk("post_rst_gnt0", 32'(gnt0), 1);
    chk("post_rst_gnt1", 32'(gnt1), 0);

    // fixed priority: port 1 starves until port 0 drops
    @(posedge clk);
    #1;
    zero_in();
    for (int k = 0; k < 3; k++) begin
      fp_req0 = 1; fp_req1 = 1;
      #3;
      chk("fp_gnt0_win", 32'(fp_gnt0), 1);
      chk("fp_gnt1_wait", 32'(fp_gnt1), 0);
      @(posedge clk);
      #1;
    end
    fp_req0 = 0;
    #3;
    chk("fp_gnt1_after", 32'(fp_gnt1), 1);
    chk("fp_gnt0_after", 32'(fp_gnt0), 0);
    @(posedge clk);
    #1;
    fp_req1 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
